// File: rtl/flag_event_arbiter_pkg.sv
// Shared types and limits for the flag event arbiter.
package flag_event_arbiter_pkg;

  localparam int N_CH_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/flag_fall_latch.sv
// One flag channel: falling-edge detector feeding a pending bit and a sticky overflow bit.
module flag_fall_latch
  import flag_event_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flag_i,
  input  logic en_i,
  input  logic grant_clr_i,
  input  logic ovf_clr_i,
  output logic pending_o,
  output logic ovf_o
);

  logic prev_q, pending_q, ovf_q;
  logic pending_d, ovf_d;
  logic fall, ovf_set;

  always_comb begin
    fall      = prev_q & ~flag_i;
    // A fall landing on the grant edge is a fresh event, not an overflow.
    ovf_set   = en_i & fall & pending_q & ~grant_clr_i;
    pending_d = pending_q;
    if (!en_i)            pending_d = 1'b0;
    else if (fall)        pending_d = 1'b1;
    else if (grant_clr_i) pending_d = 1'b0;
    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      prev_q    <= flag_i;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/flag_event_arbiter.sv
// Collects per-channel flag-fall events and presents them one at a time, round-robin, over a valid/ready port.
module flag_event_arbiter
  import flag_event_arbiter_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_flag,
  input  logic [N_CH-1:0] ch_en,
  input  logic            evt_ready,
  input  logic [N_CH-1:0] ovf_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] ovf
);

  arb_state_e      state_q;
  logic            evt_valid_q;
  logic [ID_W-1:0] evt_id_q, last_q;

  logic [N_CH-1:0] req, grant_clr;
  logic            any_req, do_grant, win_found;
  logic [ID_W-1:0] win_id;
  int              idx;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    flag_fall_latch u_latch (
      .clk         (clk),
      .rst         (rst),
      .flag_i      (in_flag[g]),
      .en_i        (ch_en[g]),
      .grant_clr_i (grant_clr[g]),
      .ovf_clr_i   (ovf_clr[g]),
      .pending_o   (pending[g]),
      .ovf_o       (ovf[g])
    );
  end

  // A pending bit on a channel being disabled this cycle is dropped, never granted.
  assign req     = pending & ch_en;
  assign any_req = |req;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int off = 1; off <= N_CH_MAX; off++) begin
      if (off <= N_CH && !win_found) begin
        idx = int'(last_q) + off;
        if (idx >= N_CH) idx = idx - N_CH;
        if (req[idx]) begin
          win_found = 1'b1;
          win_id    = ID_W'(idx);
        end
      end
    end
  end

  assign do_grant  = any_req && (state_q == IDLE || evt_ready);
  assign grant_clr = do_grant ? (N_CH'(1) << win_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      last_q      <= ID_W'(N_CH - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= GRANT;
            evt_valid_q <= 1'b1;
            evt_id_q    <= win_id;
            last_q      <= win_id;
          end
        end
        GRANT: begin
          if (evt_ready) begin
            if (any_req) begin
              evt_id_q <= win_id;
              last_q   <= win_id;
            end else begin
              state_q     <= IDLE;
              evt_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          evt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;

endmodule
